// File: rtl/cm0_rst_seq_sync.sv
// cm0_rst_seq_sync
//   Reset synchroniser and staggered release sequencer for the Cortex-M0 reset
//   tree. RSTIN asserts every output asynchronously. Release is synchronous:
//   a SYNC_STAGES-deep synchroniser, then a STRETCH_CYCLES hold, then channel i
//   rises STAGGER cycles after channel i-1. SYSRESETREQ re-enters the stretch
//   phase. RSTBYPASS (or PRESENT=0) routes RSTIN straight to every output.
//
// Ports
//   CLK          in   clock
//   RSTIN        in   async active-low reset (board/POR)
//   SE           in   scan enable, unused (port compatibility)
//   RSTBYPASS    in   1: RSTOUT = {NUM_RST{RSTIN}} combinationally
//   SYSRESETREQ  in   synchronous software reset request, active-high
//   RSTOUT       out  active-low resets, bit 0 releases first
//   RSTREQACK    out  one-cycle acknowledge of an accepted SYSRESETREQ
//   RST_BUSY     out  high while any sequenced output is still low

// One output channel: registered reset, async-cleared, raised once the
// shared counter reaches this channel's release point.
module cm0_rst_seq_sync_ch #(
  parameter int CW  = 4,
  parameter int THR = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [CW-1:0] i_cnt,
  output logic          o_rel,
  output logic          o_rst_n
);
  localparam logic [CW-1:0] THR_C = CW'(THR);

  logic r_rst_n;

  assign o_rel   = (i_cnt >= THR_C);
  assign o_rst_n = r_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_rst_n <= 1'b0;
    else if (i_clr)          r_rst_n <= 1'b0;
    else if (i_en && o_rel)  r_rst_n <= 1'b1;
  end
endmodule

module cm0_rst_seq_sync #(
  parameter int PRESENT        = 1,
  parameter int NUM_RST        = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 4,
  parameter int STAGGER        = 2
) (
  input  logic               CLK,
  input  logic               RSTIN,
  input  logic               SE,
  input  logic               RSTBYPASS,
  input  logic               SYSRESETREQ,
  output logic [NUM_RST-1:0] RSTOUT,
  output logic               RSTREQACK,
  output logic               RST_BUSY
);
  localparam int CW = $clog2(STRETCH_CYCLES + (NUM_RST-1)*STAGGER + 2);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req;
  logic                   r_ack;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;

  logic                   w_sync;
  logic [CW-1:0]          w_cnt_inc;
  logic [CW-1:0]          w_cnt_nxt;
  logic [1:0]             w_state_nxt;
  logic                   w_ack_nxt;
  logic                   w_ch_en;
  logic                   w_ch_clr;
  logic [NUM_RST-1:0]     w_rel;
  logic [NUM_RST-1:0]     w_rstout;
  logic                   w_bypass;
  logic                   w_unused;

  assign w_unused = SE;

  // Plain shift of constant 1: once RSTIN is high the chain only ever moves
  // 0->1, so the last stage cannot glitch.
  always_ff @(posedge CLK or negedge RSTIN) begin
    if (!RSTIN) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Request is registered so the FSM acts on it one edge after sampling.
  always_ff @(posedge CLK or negedge RSTIN) begin
    if (!RSTIN) r_req <= 1'b0;
    else        r_req <= SYSRESETREQ;
  end

  // Saturating increment; never wraps back into a release window.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

  for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_ch
    cm0_rst_seq_sync_ch #(
      .CW  (CW),
      .THR (STRETCH_CYCLES + gi*STAGGER)
    ) u_ch (
      .i_clk   (CLK),
      .i_rst_n (RSTIN),
      .i_en    (w_ch_en),
      .i_clr   (w_ch_clr),
      .i_cnt   (w_cnt_inc),
      .o_rel   (w_rel[gi]),
      .o_rst_n (w_rstout[gi])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_ch_en     = 1'b0;
    w_ch_clr    = 1'b0;
    if (r_state == S_HOLD) begin
      w_cnt_nxt = '0;
      if (w_sync) w_state_nxt = S_STRETCH;
    end else if (r_req) begin
      // Request beats any release due on this edge. Only a request that
      // actually pulls outputs low (RELEASE/RUN) is acknowledged.
      w_cnt_nxt   = '0;
      w_ch_clr    = 1'b1;
      w_state_nxt = S_STRETCH;
      w_ack_nxt   = (r_state != S_STRETCH);
    end else if (r_state != S_RUN) begin
      w_cnt_nxt = w_cnt_inc;
      w_ch_en   = 1'b1;
      if (&w_rel)        w_state_nxt = S_RUN;
      else if (w_rel[0]) w_state_nxt = S_RELEASE;
    end
  end

  always_ff @(posedge CLK or negedge RSTIN) begin
    if (!RSTIN) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign w_bypass  = RSTBYPASS || (PRESENT == 0);
  assign RSTOUT    = w_bypass ? {NUM_RST{RSTIN}} : w_rstout;
  assign RSTREQACK = (PRESENT != 0) ? r_ack : 1'b0;
  assign RST_BUSY  = (PRESENT != 0) ? (r_state != S_RUN) : ~RSTIN;
endmodule
